// File: rtl/bus_arb_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : bus_arb_pkg                                                     |
// | Purpose  : Shared types and constants for the MMIO bus arbiter: FSM state |
// |            encoding, default bus widths, timeout read-back pattern and    |
// |            the MMIO slave base addresses.                                 |
// | Ports    : none (package)                                                 |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int BUS_ADDR_W = 64;
  localparam int BUS_DATA_W = 64;

  // Read data returned to a master whose transfer timed out.
  localparam logic [63:0] ERR_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

  // MMIO slave map.
  localparam logic [63:0] ART_BASE  = 64'h8000_0000;
  localparam logic [63:0] KEY_BASE  = 64'h8000_0010;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : rr_picker                                                      |
// | Purpose  : Combinational round-robin selector. Scans the request vector  |
// |            starting one position after the previous winner, wrapping,     |
// |            and reports the first set bit.                                 |
// | Ports    : i_req   [N-1:0]  request vector                                |
// |            i_last  [IW-1:0] index of the previous winner                  |
// |            o_gnt   [N-1:0]  one-hot winner (0 when no request)           |
// |            o_idx   [IW-1:0] winner index                                  |
// |            o_valid          at least one request present                  |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int w_pos;

  // Offsets 1..N visit every requester once, ending on the previous winner,
  // so the previous winner has the lowest priority.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int k = 1; k <= N; k++) begin
      w_pos = (int'(i_last) + k) % N;
      if (!o_valid && i_req[w_pos]) begin
        o_valid      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = IW'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : bus_arbiter                                                    |
// | Purpose  : Round-robin arbiter sharing the single MMIO bus between        |
// |            NUM_MASTERS requesters, one transaction in flight at a time.   |
// |            Sequence per transaction: IDLE (arbitrate) -> XFER (strobe     |
// |            held until bus_ready) -> RESP (one-cycle ack) -> IDLE.        |
// | Ports    : clk, reset (sync, active high)                                 |
// |            m_req/m_we/m_addr/m_wdata : per-master request, packed         |
// |            m_gnt/m_ack/m_rdata/m_err : per-master grant/completion        |
// |            bus_address/bus_write_data/bus_write_enable/bus_read_enable    |
// |            bus_read_data/bus_ready   : slave strobe interface             |
// | Options  : BUS_ARB_TIMEOUT_EN - abort XFER after TIMEOUT_CYC cycles with  |
// |            m_err=1 and all-ones read data. Undefined: wait forever.      |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  output logic [ADDR_W-1:0]             bus_address,
  output logic [DATA_W-1:0]             bus_write_data,
  output logic                          bus_write_enable,
  output logic                          bus_read_enable,
  input  logic [DATA_W-1:0]             bus_read_data,
  input  logic                          bus_ready
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("bus_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYC >= 1");
  end

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic [IW-1:0]          r_last;
  logic [IW-1:0]          r_owner;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [NUM_MASTERS-1:0] r_ack;
  logic [DATA_W-1:0]      r_rdata;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic                   r_wen;
  logic                   r_ren;

  logic [NUM_MASTERS-1:0] w_pick_gnt;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_pick_valid;
  logic                   w_expire;

  rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .i_req   (m_req),
    .i_last  (r_last),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_tcnt;
  logic          r_err;

  // Counter holds the number of completed XFER cycles without bus_ready, so
  // the last permitted cycle is the one where it reads TIMEOUT_CYC-1.
  assign w_expire = (r_state == XFER) && !bus_ready &&
                    (r_tcnt == CW'(TIMEOUT_CYC - 1));
  assign m_err    = r_err;
`else
  assign w_expire = 1'b0;
  assign m_err    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; bus_ready outside XFER has no effect.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_state_nxt = XFER;
      XFER:    if (bus_ready || w_expire) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latched request, strobes, grant/ack and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last  <= IW'(NUM_MASTERS - 1);
      r_owner <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
      r_ren   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      r_tcnt  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_owner <= w_pick_idx;
            r_gnt   <= w_pick_gnt;
            r_addr  <= m_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
            r_wdata <= m_wdata[int'(w_pick_idx)*DATA_W +: DATA_W];
            r_wen   <= m_we[w_pick_idx];
            r_ren   <= ~m_we[w_pick_idx];
`ifdef BUS_ARB_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
          end
        end
        XFER: begin
          if (bus_ready) begin
            if (r_ren) r_rdata <= bus_read_data;
            r_wen  <= 1'b0;
            r_ren  <= 1'b0;
            r_ack  <= r_gnt;
            r_last <= r_owner;
`ifdef BUS_ARB_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (w_expire) begin
            r_rdata <= DATA_W'(ERR_RDATA);
            r_err   <= 1'b1;
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_ack   <= r_gnt;
            r_last  <= r_owner;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        RESP: begin
          r_ack <= '0;
          r_gnt <= '0;
        end
        default: begin
          r_ack <= '0;
          r_gnt <= '0;
        end
      endcase
    end
  end

  assign m_gnt            = r_gnt;
  assign m_ack            = r_ack;
  assign m_rdata          = r_rdata;
  assign bus_address      = r_addr;
  assign bus_write_data   = r_wdata;
  assign bus_write_enable = r_wen;
  assign bus_read_enable  = r_ren;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_bus_arbiter                                                 |
// | Purpose  : Directed self-checking bench for bus_arbiter (2 masters,      |
// |            TIMEOUT_CYC=8). Inputs change and outputs are sampled 1 time  |
// |            unit after each rising edge.                                   |
// | Ports    : none                                                           |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [63:0] ART  = 64'h8000_0000;
  localparam logic [63:0] KEY  = 64'h8000_0010;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     m_req;
  logic [NM-1:0]     m_we;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_gnt;
  logic [NM-1:0]     m_ack;
  logic [DW-1:0]     m_rdata;
  logic              m_err;
  logic [AW-1:0]     bus_address;
  logic [DW-1:0]     bus_write_data;
  logic              bus_write_enable;
  logic              bus_read_enable;
  logic [DW-1:0]     bus_read_data;
  logic              bus_ready;

  int n_vec = 0;
  int n_err = 0;

  bus_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .m_req            (m_req),
    .m_we             (m_we),
    .m_addr           (m_addr),
    .m_wdata          (m_wdata),
    .m_gnt            (m_gnt),
    .m_ack            (m_ack),
    .m_rdata          (m_rdata),
    .m_err            (m_err),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data),
    .bus_ready        (bus_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    bus_read_data = '0; bus_ready = 1'b0;
    tick(); tick();
    n_vec++; if (m_gnt !== 2'b00 || m_ack !== 2'b00) begin n_err++;
      $display("FAIL reset_gnt_ack: got gnt=%b ack=%b expected 00/00", m_gnt, m_ack); end
    n_vec++; if (m_rdata !== 64'd0 || m_err !== 1'b0) begin n_err++;
      $display("FAIL reset_rdata_err: got %h/%b expected 0/0", m_rdata, m_err); end
    n_vec++; if (bus_address !== 64'd0 || bus_write_data !== 64'd0) begin n_err++;
      $display("FAIL reset_bus: got addr=%h wdata=%h expected 0/0", bus_address, bus_write_data); end
    n_vec++; if (bus_write_enable !== 1'b0 || bus_read_enable !== 1'b0) begin n_err++;
      $display("FAIL reset_en: got we=%b re=%b expected 0/0", bus_write_enable, bus_read_enable); end
    reset = 1'b0;
    tick();
    n_vec++; if (m_gnt !== 2'b00 || bus_read_enable !== 1'b0) begin n_err++;
      $display("FAIL idle_no_req: got gnt=%b re=%b expected 00/0", m_gnt, bus_read_enable); end
  endtask

  task automatic test_single_read();
    m_req = 2'b01; m_we = 2'b00; m_addr[0 +: AW] = KEY;
    tick();  // XFER cycle 1
    n_vec++; if (m_gnt !== 2'b01 || bus_read_enable !== 1'b1 || bus_write_enable !== 1'b0) begin n_err++;
      $display("FAIL read_x1: got gnt=%b re=%b we=%b expected 01/1/0", m_gnt, bus_read_enable, bus_write_enable); end
    n_vec++; if (bus_address !== KEY || m_ack !== 2'b00) begin n_err++;
      $display("FAIL read_addr: got addr=%h ack=%b expected %h/00", bus_address, m_ack, KEY); end
    tick();  // XFER cycle 2
    n_vec++; if (bus_read_enable !== 1'b1 || m_ack !== 2'b00) begin n_err++;
      $display("FAIL read_x2: got re=%b ack=%b expected 1/00", bus_read_enable, m_ack); end
    bus_ready = 1'b1; bus_read_data = 64'h41;
    tick();  // RESP
    bus_ready = 1'b0; m_req = 2'b00; bus_read_data = 64'h0;
    n_vec++; if (m_ack !== 2'b01 || m_rdata !== 64'h41 || m_err !== 1'b0) begin n_err++;
      $display("FAIL read_resp: got ack=%b rdata=%h err=%b expected 01/41/0", m_ack, m_rdata, m_err); end
    n_vec++; if (bus_read_enable !== 1'b0 || m_gnt !== 2'b01) begin n_err++;
      $display("FAIL read_resp_en: got re=%b gnt=%b expected 0/01", bus_read_enable, m_gnt); end
    tick();  // IDLE
    n_vec++; if (m_ack !== 2'b00 || m_gnt !== 2'b00) begin n_err++;
      $display("FAIL read_idle: got ack=%b gnt=%b expected 00/00", m_ack, m_gnt); end
  endtask

  task automatic test_contention();
    logic [63:0] exp_rd;
    int          exp_m;
    reset = 1'b1; tick(); reset = 1'b0;
    m_req = 2'b11; m_we = 2'b01;
    m_addr[0 +: AW] = ART; m_wdata[0 +: DW] = 64'h41;
    m_addr[AW +: AW] = KEY; m_wdata[DW +: DW] = 64'h77;
    bus_ready = 1'b1;
    exp_rd = 64'h0;
    for (int t = 0; t < 4; t++) begin
      exp_m = t % 2;
      bus_read_data = (exp_m == 1) ? 64'h55 : 64'h66;
      tick();  // XFER
      n_vec++; if (m_gnt !== 2'(1 << exp_m)) begin n_err++;
        $display("FAIL cont_gnt[%0d]: got %b expected %b", t, m_gnt, 2'(1 << exp_m)); end
      n_vec++; if (bus_write_enable !== (exp_m == 0) || bus_read_enable !== (exp_m == 1)) begin n_err++;
        $display("FAIL cont_en[%0d]: got we=%b re=%b expected %b/%b", t, bus_write_enable,
                 bus_read_enable, exp_m == 0, exp_m == 1); end
      n_vec++; if (bus_address !== ((exp_m == 0) ? ART : KEY)) begin n_err++;
        $display("FAIL cont_addr[%0d]: got %h expected %h", t, bus_address, (exp_m == 0) ? ART : KEY); end
      tick();  // RESP
      if (exp_m == 1) exp_rd = 64'h55;
      n_vec++; if (m_ack !== 2'(1 << exp_m) || m_rdata !== exp_rd) begin n_err++;
        $display("FAIL cont_ack[%0d]: got ack=%b rdata=%h expected %b/%h", t, m_ack, m_rdata,
                 2'(1 << exp_m), exp_rd); end
      tick();  // IDLE
      n_vec++; if (m_ack !== 2'b00 || m_gnt !== 2'b00) begin n_err++;
        $display("FAIL cont_idle[%0d]: got ack=%b gnt=%b expected 00/00", t, m_ack, m_gnt); end
    end
    m_req = 2'b00; bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_stability();
    m_req = 2'b01; m_we = 2'b01; m_addr[0 +: AW] = ART; m_wdata[0 +: DW] = 64'hAB;
    bus_ready = 1'b0;
    tick();  // XFER cycle 1
    m_addr[0 +: AW] = 64'h1234; m_wdata[0 +: DW] = 64'h99; m_we = 2'b00;
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (bus_address !== ART || bus_write_data !== 64'hAB ||
                   bus_write_enable !== 1'b1 || bus_read_enable !== 1'b0) begin n_err++;
        $display("FAIL stab[%0d]: got addr=%h wd=%h we=%b re=%b expected %h/ab/1/0", c,
                 bus_address, bus_write_data, bus_write_enable, bus_read_enable, ART); end
      if (c < 4) tick();
    end
    bus_ready = 1'b1;
    tick();  // RESP
    bus_ready = 1'b0; m_req = 2'b00;
    n_vec++; if (m_ack !== 2'b01 || bus_write_enable !== 1'b0) begin n_err++;
      $display("FAIL stab_ack: got ack=%b we=%b expected 01/0", m_ack, bus_write_enable); end
    tick();
  endtask

  task automatic test_reset_mid();
    m_req = 2'b10; m_we = 2'b00; m_addr[AW +: AW] = KEY; bus_ready = 1'b0;
    tick();  // XFER cycle 1
    n_vec++; if (m_gnt !== 2'b10) begin n_err++;
      $display("FAIL rmid_gnt: got %b expected 10", m_gnt); end
    tick();  // XFER cycle 2
    reset = 1'b1; bus_ready = 1'b1; bus_read_data = 64'h33;
    tick();
    n_vec++; if (m_ack !== 2'b00 || m_gnt !== 2'b00 || bus_read_enable !== 1'b0 ||
                 bus_write_enable !== 1'b0) begin n_err++;
      $display("FAIL rmid_out: got ack=%b gnt=%b re=%b we=%b expected all 0", m_ack, m_gnt,
               bus_read_enable, bus_write_enable); end
    n_vec++; if (bus_address !== 64'd0 || m_rdata !== 64'd0) begin n_err++;
      $display("FAIL rmid_data: got addr=%h rdata=%h expected 0/0", bus_address, m_rdata); end
    reset = 1'b0; bus_ready = 1'b0; m_req = 2'b11; m_addr[0 +: AW] = ART;
    tick();  // XFER
    n_vec++; if (m_gnt !== 2'b01) begin n_err++;
      $display("FAIL rmid_first: got %b expected 01", m_gnt); end
    bus_ready = 1'b1;
    tick();  // RESP
    m_req = 2'b00; bus_ready = 1'b0;
    n_vec++; if (m_ack !== 2'b01) begin n_err++;
      $display("FAIL rmid_ack: got %b expected 01", m_ack); end
    tick();
  endtask

  task automatic test_timeout();
    m_req = 2'b01; m_we = 2'b00; m_addr[0 +: AW] = KEY; bus_ready = 1'b0;
    bus_read_data = 64'h12;
    tick();  // XFER cycle 1
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 2; c <= 8; c++) begin
      tick();
      n_vec++; if (m_ack !== 2'b00 || bus_read_enable !== 1'b1) begin n_err++;
        $display("FAIL to_wait[%0d]: got ack=%b re=%b expected 00/1", c, m_ack, bus_read_enable); end
    end
    tick();  // RESP after 8 XFER cycles
    m_req = 2'b00;
    n_vec++; if (m_ack !== 2'b01 || m_err !== 1'b1 || m_rdata !== ONES) begin n_err++;
      $display("FAIL to_resp: got ack=%b err=%b rdata=%h expected 01/1/%h", m_ack, m_err, m_rdata, ONES); end
    n_vec++; if (bus_read_enable !== 1'b0) begin n_err++;
      $display("FAIL to_en: got %b expected 0", bus_read_enable); end
    tick();
`else
    begin
      int acks = 0;
      for (int c = 0; c < 100; c++) begin
        tick();
        if (m_ack !== 2'b00) acks++;
      end
      n_vec++; if (acks != 0 || bus_read_enable !== 1'b1) begin n_err++;
        $display("FAIL to_hang: got %0d acks re=%b expected 0 acks re=1", acks, bus_read_enable); end
    end
    bus_ready = 1'b1;
    tick();  // RESP
    bus_ready = 1'b0; m_req = 2'b00;
    n_vec++; if (m_ack !== 2'b01 || m_err !== 1'b0 || m_rdata !== 64'h12) begin n_err++;
      $display("FAIL to_late: got ack=%b err=%b rdata=%h expected 01/0/12", m_ack, m_err, m_rdata); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_stability();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single 64-bit MMIO bus (UART/ART at 0x8000_0000, keyboard at 0x8000_0010) between NUM_MASTERS requesters.
- Requesters are the riscv64 core load/store path and the interrupt/keyboard service engine.
- Round-robin arbitration; one transaction in flight at a time.
- Masters see a req/ack handshake. Slaves see the existing bus_* strobe interface plus a bus_ready completion signal.

Parameters:
NUM_MASTERS, 2, number of requesters (2..8)
ADDR_W, 64, bus address width
DATA_W, 64, bus data width
TIMEOUT_CYC, 255, cycles in XFER before timeout (used only with BUS_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_req  in  NUM_MASTERS  per-master request; held until matching m_ack
m_we  in  NUM_MASTERS  per-master 1=write, 0=read
m_addr  in  NUM_MASTERS*ADDR_W  packed per-master address, master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  NUM_MASTERS*DATA_W  packed per-master write data
m_gnt  out  NUM_MASTERS  one-hot current bus owner (XFER and RESP only)
m_ack  out  NUM_MASTERS  one-cycle completion pulse to owner
m_rdata  out  DATA_W  read data, valid while m_ack is high
m_err  out  1  error flag, valid with m_ack
bus_address  out  ADDR_W  slave address
bus_write_data  out  DATA_W  slave write data
bus_write_enable  out  1  write strobe, held until bus_ready
bus_read_enable  out  1  read strobe, held until bus_ready
bus_read_data  in  DATA_W  slave read data, sampled when bus_ready=1
bus_ready  in  1  slave completion

Behaviour:
- Reset: all outputs 0 (m_gnt, m_ack, m_rdata, m_err, bus_address, bus_write_data, both enables); state=IDLE; last_grant=NUM_MASTERS-1, so master 0 wins first.
- Reset mid-transaction: enables drop at that edge and no ack is issued; the master re-requests.
- FSM: IDLE -> XFER -> RESP -> IDLE.
- IDLE, some m_req set:
  - Winner = first set bit scanning from last_grant+1, wrapping modulo NUM_MASTERS.
  - Latch winner index, address, wdata and we.
  - Next cycle: state=XFER, m_gnt=onehot(winner), bus_address/bus_write_data driven, bus_write_enable=we, bus_read_enable=~we.
  - Exactly one enable is high in XFER.
- IDLE, no request: outputs hold 0 enables; bus_address and bus_write_data keep their last values.
- XFER:
  - Strobes and address held stable while bus_ready=0.
  - On bus_ready=1: m_rdata<=bus_read_data (reads; writes leave m_rdata unchanged), m_err<=0, both enables<=0, m_ack[winner]<=1, last_grant<=winner, state=RESP.
- RESP:
  - m_ack high for this single cycle; the winner deasserts m_req in this cycle.
  - Requests are not arbitrated in RESP.
  - Next cycle: m_ack=0, m_gnt=0, state=IDLE.
- Latency: req sampled at edge N; enables high from N+1; with bus_ready in the same cycle, ack at N+2. Minimum 3 cycles per transaction.
- Changes to m_req/m_addr/m_wdata/m_we of the owner after the grant are ignored; latched copies are used.
- Simultaneous requests: round-robin guarantees any requester waits at most NUM_MASTERS-1 transactions.
- The winner still asserting m_req in IDLE after RESP counts as a new request, at lowest priority.
- bus_ready while IDLE or RESP is ignored.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit (clog2(TIMEOUT_CYC+1)) counter cleared on entry to XFER, incremented each XFER cycle without bus_ready.
  - On reaching TIMEOUT_CYC: behave as completion with m_err=1 and m_rdata=all ones (ERR_RDATA); enables drop; state=RESP.
  - bus_ready in the same cycle as expiry wins: normal completion, m_err=0.
- Undefined: no counter; XFER waits indefinitely; m_err tied 0.

Decomposition:
- Package bus_arb_pkg holds:
  - state enum {IDLE, XFER, RESP}
  - ADDR_W/DATA_W defaults
  - ERR_RDATA=64'hFFFF_FFFF_FFFF_FFFF
  - ART_BASE=64'h8000_0000, KEY_BASE=64'h8000_0010
- Sub-module rr_picker: combinational round-robin; inputs req vector and last_grant; outputs one-hot grant and index with a valid flag. Reused by the planned interrupt controller.

Test Plan:
- Single read: m_req[0]=1, we=0, addr=KEY_BASE; slave ready 2 cycles after strobe with data 0x41 -> bus_read_enable high 2 cycles, m_ack[0] pulse one cycle later, m_rdata=0x41, m_err=0.
- Contention: m_req=2'b11 held continuously; master 0 writes 0x41 to ART_BASE, master 1 reads KEY_BASE; ready immediate -> grants alternate 0,1,0,1; each ack 3 cycles apart; no master is granted twice in a row.
- Stability: master 0 changes m_addr to 0x1234 during XFER with bus_ready held 0 for 5 cycles -> bus_address stays ART_BASE; strobe constant for all 5 cycles.
- Reset mid-XFER: reset asserted in the second XFER cycle -> next edge all outputs 0, no m_ack; after release master 0 (lowest index) wins first.
- Timeout (BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): bus_ready never asserted -> after 8 XFER cycles m_ack pulses with m_err=1, m_rdata=ERR_RDATA. Without the macro the same stimulus gives no ack after 100 cycles.
